// File: rtl/key_event_arbiter.sv
// Latches key press pulses, arbitrates them round-robin into a show-ahead event FIFO
// and presents key indices over valid/ready. Optional auto-repeat: define KEY_REPEAT_EN.
module key_event_arbiter #(
   parameter int N       = 4,
   parameter int IDXW    = 2,
   parameter int DEPTH   = 4,
   parameter int AW      = 2,
   parameter int RPT_DLY = 24000000,
   parameter int RPT_PER = 6000000,
   parameter int RPT_W   = 25
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    key_pulse,
   input  logic [N-1:0]    key_n,
   output logic            ev_valid,
   input  logic            ev_ready,
   output logic [IDXW-1:0] ev_idx,
   output logic            ev_repeat,
   output logic            overflow,
   input  logic            clr_ovf
);

   localparam int EW = IDXW + 1;

   logic [N-1:0]    pending;
   logic [IDXW-1:0] last;
   logic [EW-1:0]   mem [DEPTH];
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            any_pend;
   logic            grant;
   logic            rpt_grant;
   logic [IDXW-1:0] grant_idx;
   logic [N-1:0]    grant_mask;
   logic [EW-1:0]   push_data;
   logic [EW-1:0]   head;
   logic            ovf_set;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // Round-robin search starting just after the most recently granted key
   always_comb begin
      any_pend  = 1'b0;
      grant_idx = '0;
      for (int k = 1; k <= N; k++) begin
         if (!any_pend && pending[(int'(last) + k) % N]) begin
            any_pend  = 1'b1;
            grant_idx = IDXW'((int'(last) + k) % N);
         end
      end
   end

   assign grant = any_pend & ~full;

   always_comb begin
      grant_mask = '0;
      if (grant) grant_mask[grant_idx] = 1'b1;
   end

   assign ovf_set = |(key_pulse & pending & ~grant_mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         last     <= IDXW'(N - 1);
         overflow <= 1'b0;
      end else begin
         pending <= (pending & ~grant_mask) | key_pulse;
         if (grant) last <= grant_idx;
         if (ovf_set) overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

`ifdef KEY_REPEAT_EN
   logic [IDXW-1:0]  tgt;
   logic             active;
   logic             first;
   logic             rpt_pend;
   logic [RPT_W-1:0] cnt;
   logic             held;
   logic             rpt_tick;

   assign held      = active & ~key_n[tgt];
   assign rpt_tick  = held && (cnt == (first ? RPT_W'(RPT_DLY - 1) : RPT_W'(RPT_PER - 1)));
   assign rpt_grant = rpt_pend & ~(|pending) & ~full;
   assign push_data = grant ? {1'b0, grant_idx} : {1'b1, tgt};

   // A fresh press retargets the tracker and drops any stale repeat of the old key
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt      <= '0;
         active   <= 1'b0;
         first    <= 1'b0;
         rpt_pend <= 1'b0;
         cnt      <= '0;
      end else if (grant) begin
         tgt      <= grant_idx;
         active   <= 1'b1;
         first    <= 1'b1;
         rpt_pend <= 1'b0;
         cnt      <= '0;
      end else if (active && key_n[tgt]) begin
         active   <= 1'b0;
         rpt_pend <= 1'b0;
      end else if (rpt_tick) begin
         rpt_pend <= 1'b1;
         cnt      <= '0;
         first    <= 1'b0;
      end else begin
         if (held) cnt <= cnt + 1'b1;
         if (rpt_grant) rpt_pend <= 1'b0;
      end
   end
`else
   logic unused_rpt;

   assign rpt_grant  = 1'b0;
   assign push_data  = {1'b0, grant_idx};
   assign unused_rpt = ^{key_n, 32'(RPT_DLY), 32'(RPT_PER), 32'(RPT_W)};
`endif

   assign push = grant | rpt_grant;
   assign pop  = ~empty & ev_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign head      = mem[rd_ptr[AW-1:0]];
   assign ev_valid  = ~empty;
   assign ev_idx    = empty ? '0 : head[IDXW-1:0];
   assign ev_repeat = ~empty & head[IDXW];

endmodule

// File: tb/tb_key_event_arbiter.sv
// Self-checking bench for key_event_arbiter: directed scenarios plus random traffic,
// all compared against a queue-based event model.
module tb_key_event_arbiter;

   localparam int N       = 4;
   localparam int IDXW    = 2;
   localparam int DEPTH   = 4;
   localparam int AW      = 2;
   localparam int RPT_DLY = 20;
   localparam int RPT_PER = 5;
   localparam int RPT_W   = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    key_pulse = '0;
   logic [N-1:0]    key_n = '1;
   logic            ev_ready = 1'b0;
   logic            clr_ovf = 1'b0;
   logic            ev_valid;
   logic [IDXW-1:0] ev_idx;
   logic            ev_repeat;
   logic            overflow;

   int total = 0;
   int bad = 0;

   // Model state: pending keys, last grant, queued events (idx + 16 for a repeat)
   logic [N-1:0] m_pend;
   int           m_last;
   int           m_q[$];
   logic         m_ovf;
`ifdef KEY_REPEAT_EN
   int m_tgt;
   bit m_active;
   int m_held;
   bit m_rpend;
`endif

   key_event_arbiter #(
      .N(N), .IDXW(IDXW), .DEPTH(DEPTH), .AW(AW),
      .RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER), .RPT_W(RPT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse), .key_n(key_n),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_idx(ev_idx),
      .ev_repeat(ev_repeat), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_pend = '0;
      m_last = N - 1;
      m_q.delete();
      m_ovf = 1'b0;
`ifdef KEY_REPEAT_EN
      m_tgt = 0;
      m_active = 0;
      m_held = 0;
      m_rpend = 0;
`endif
   endfunction

   function automatic void model_step();
      bit full = (m_q.size() >= DEPTH);
      int g = -1;
      bit rg = 0;
      bit ovf_set = 0;
      int rpt_entry = 0;
      if (!full)
         for (int k = 1; k <= N; k++) begin
            int j = (m_last + k) % N;
            if (g < 0 && m_pend[j]) g = j;
         end
      for (int i = 0; i < N; i++)
         if (key_pulse[i] && m_pend[i] && g != i) ovf_set = 1;
      m_ovf = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
`ifdef KEY_REPEAT_EN
      rg = (m_pend == '0) && m_rpend && !full;
      if (rg) rpt_entry = 16 + m_tgt;
      if (g >= 0) begin
         m_tgt = g; m_active = 1; m_held = 0; m_rpend = 0;
      end else if (m_active && key_n[m_tgt]) begin
         m_active = 0; m_rpend = 0;
      end else if (m_active) begin
         m_held++;
         if (rg) m_rpend = 0;
         if (m_held == RPT_DLY || (m_held > RPT_DLY && (m_held - RPT_DLY) % RPT_PER == 0))
            m_rpend = 1;
      end
`endif
      if (m_q.size() > 0 && ev_ready) void'(m_q.pop_front());
      if (g >= 0) begin
         m_q.push_back(g);
         m_last = g;
         m_pend[g] = 1'b0;
      end else if (rg) begin
         m_q.push_back(rpt_entry);
      end
      m_pend = m_pend | key_pulse;
   endfunction

   function automatic logic [IDXW+2:0] model_exp();
      if (m_q.size() == 0) return {1'b0, {IDXW{1'b0}}, 1'b0, m_ovf};
      return {1'b1, IDXW'(m_q[0] % 16), (m_q[0] >= 16), m_ovf};
   endfunction

   function automatic logic [IDXW+2:0] dut_obs();
      return {ev_valid, ev_idx & {IDXW{ev_valid}}, ev_valid & ev_repeat, overflow};
   endfunction

   function automatic int seq_code(input int q[$]);
      int c = 1;
      foreach (q[i]) c = c * 8 + q[i];
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      else model_reset();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      key_pulse = '0;
      clr_ovf = 1'b0;
      key_n = '1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({ev_valid, ev_idx, ev_repeat, overflow} !== 5'b0) begin
         bad++;
         $display("[TB] FAIL reset_outputs got=%b want=%b", {ev_valid, ev_idx, ev_repeat, overflow}, 5'b0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (dut_obs() !== model_exp()) begin
            bad++;
            $display("[TB] FAIL reset_idle cyc=%0d got=%b want=%b", i, dut_obs(), model_exp());
         end
      end
   endtask

   task automatic test_single_press();
      int nvalid = 0;
      int first_at = -1;
      int idx_seen = -1;
      do_reset();
      ev_ready = 1'b1;
      key_pulse = 4'b0100;
      tick();
      key_pulse = '0;
      total++;
      if (ev_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL single_early got=%b want=0", ev_valid);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if (dut_obs() !== model_exp()) begin
            bad++;
            $display("[TB] FAIL single_model cyc=%0d got=%b want=%b", i, dut_obs(), model_exp());
         end
         if (ev_valid) begin
            nvalid++;
            if (first_at < 0) begin first_at = i; idx_seen = int'(ev_idx); end
         end
      end
      total++;
      if (nvalid != 1 || first_at != 0 || idx_seen != 2 || ev_repeat !== 1'b0) begin
         bad++;
         $display("[TB] FAIL single_press got valid_cycles=%0d first=%0d idx=%0d want 1/0/2",
                  nvalid, first_at, idx_seen);
      end
   endtask

   task automatic run_collect(input logic [N-1:0] pulses, input int cycles, output int got[$]);
      got.delete();
      key_pulse = pulses;
      for (int i = 0; i < cycles; i++) begin
         if (ev_valid && ev_ready) got.push_back(int'(ev_idx));
         tick();
         key_pulse = '0;
         total++;
         if (dut_obs() !== model_exp()) begin
            bad++;
            $display("[TB] FAIL collect_model cyc=%0d got=%b want=%b", i, dut_obs(), model_exp());
         end
      end
   endtask

   task automatic test_simultaneous();
      int got[$];
      int want[$];
      do_reset();
      ev_ready = 1'b1;
      run_collect(4'b1011, 8, got);
      want = '{0, 1, 3};
      total++;
      if (seq_code(got) != seq_code(want)) begin
         bad++;
         $display("[TB] FAIL simul_1011 got=%o want=%o", seq_code(got), seq_code(want));
      end
      run_collect(4'b0011, 8, got);
      want = '{0, 1};
      total++;
      if (seq_code(got) != seq_code(want)) begin
         bad++;
         $display("[TB] FAIL simul_0011 got=%o want=%o", seq_code(got), seq_code(want));
      end
   endtask

   task automatic test_backpressure();
      int got[$];
      int want[$];
      do_reset();
      ev_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         key_pulse = (k < 4) ? N'(1 << k) : N'(1);
         tick();
         total++;
         if (dut_obs() !== model_exp()) begin
            bad++;
            $display("[TB] FAIL bp_fill cyc=%0d got=%b want=%b", k, dut_obs(), model_exp());
         end
         if (k == 4) begin
            total++;
            if (overflow !== 1'b0) begin
               bad++;
               $display("[TB] FAIL bp_no_ovf_yet got=%b want=0", overflow);
            end
         end
      end
      key_pulse = '0;
      tick();
      tick();
      total++;
      if ({overflow, ev_valid, ev_idx} !== 4'b1100) begin
         bad++;
         $display("[TB] FAIL bp_held got=%b want=1100", {overflow, ev_valid, ev_idx});
      end
      ev_ready = 1'b1;
      run_collect('0, 10, got);
      want = '{0, 1, 2, 3, 0};
      total++;
      if (seq_code(got) != seq_code(want)) begin
         bad++;
         $display("[TB] FAIL bp_drain got=%o want=%o", seq_code(got), seq_code(want));
      end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      total++;
      if (overflow !== 1'b0) begin
         bad++;
         $display("[TB] FAIL bp_clr got=%b want=0", overflow);
      end
   endtask

   task automatic test_ovf_priority();
      do_reset();
      ev_ready = 1'b0;
      key_pulse = 4'b1111;
      tick();
      key_pulse = '0;
      for (int i = 0; i < 4; i++) tick();
      key_pulse = 4'b0010;
      tick();
      clr_ovf = 1'b1;
      tick();
      key_pulse = '0;
      clr_ovf = 1'b0;
      total++;
      if (overflow !== 1'b1 || dut_obs() !== model_exp()) begin
         bad++;
         $display("[TB] FAIL ovf_set_wins got=%b want=1", overflow);
      end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      total++;
      if (overflow !== 1'b0) begin
         bad++;
         $display("[TB] FAIL ovf_clear got=%b want=0", overflow);
      end
   endtask

   task automatic test_reset_mid();
      int nvalid = 0;
      do_reset();
      ev_ready = 1'b0;
      key_pulse = 4'b0111;
      tick();
      key_pulse = '0;
      for (int i = 0; i < 4; i++) tick();
      total++;
      if (ev_valid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL mid_queued got=%b want=1", ev_valid);
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (ev_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL mid_async got=%b want=0", ev_valid);
      end
      tick();
      rst_n = 1'b1;
      ev_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ev_valid) nvalid++;
      end
      total++;
      if (nvalid != 0) begin
         bad++;
         $display("[TB] FAIL mid_ghost got=%0d want=0", nvalid);
      end
      key_pulse = 4'b0001;
      for (int i = 0; i < 6; i++) begin
         tick();
         key_pulse = '0;
         if (ev_valid) nvalid++;
         total++;
         if (dut_obs() !== model_exp()) begin
            bad++;
            $display("[TB] FAIL mid_after cyc=%0d got=%b want=%b", i, dut_obs(), model_exp());
         end
      end
      total++;
      if (nvalid != 1) begin
         bad++;
         $display("[TB] FAIL mid_new_event got=%0d want=1", nvalid);
      end
   endtask

   task automatic test_repeat();
      int n_norm = 0;
      int n_rpt = 0;
      int n_late = 0;
`ifdef KEY_REPEAT_EN
      int want_rpt = 4;
`else
      int want_rpt = 0;
`endif
      do_reset();
      ev_ready = 1'b1;
      key_n = 4'b0111;
      key_pulse = 4'b1000;
      for (int i = 0; i < 52; i++) begin
         if (i == 40) key_n = '1;
         if (ev_valid && ev_repeat && ev_idx == 2'd3) begin
            n_rpt++;
            if (i > 40) n_late++;
         end else if (ev_valid && !ev_repeat && ev_idx == 2'd3) begin
            n_norm++;
         end
         tick();
         key_pulse = '0;
         total++;
         if (dut_obs() !== model_exp()) begin
            bad++;
            $display("[TB] FAIL repeat_model cyc=%0d got=%b want=%b", i, dut_obs(), model_exp());
         end
      end
      total++;
      if (n_norm != 1 || n_rpt != want_rpt || n_late != 0) begin
         bad++;
         $display("[TB] FAIL repeat_count got norm=%0d rpt=%0d late=%0d want 1/%0d/0",
                  n_norm, n_rpt, n_late, want_rpt);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         key_pulse = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         ev_ready  = ($urandom_range(0, 9) < 6);
         clr_ovf   = ($urandom_range(0, 19) == 0);
         if (i % 64 == 0) key_n = N'($urandom);
         tick();
         total++;
         if (dut_obs() !== model_exp()) begin
            bad++;
            $display("[TB] FAIL random cyc=%0d got=%b want=%b", i, dut_obs(), model_exp());
         end
      end
      key_pulse = '0;
      clr_ovf = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_simultaneous();
      test_backpressure();
      test_ovf_priority();
      test_reset_mid();
      test_repeat();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
